// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch. Counts seconds from the divider's square wave, with
// start/stop, clear and lap-freeze controlled by one-cycle button pulses.
// Every output comes straight from a flop.
module stopwatch_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Count and lap values are packed as {min_t, min_o, sec_t, sec_o}.
  localparam logic [15:0] MAX_COUNT = 16'h5959;

  state_t      state, state_n;
  logic        tick_q;
  logic        tick;
  logic        count_en;
  logic [15:0] cnt, cnt_n;
  logic [15:0] lap_reg, lap_n;
  logic        lap_on_n;
  logic        wrap_n;

  // One-second BCD increment with ripple carry; 59:59 rolls to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd9) begin
      r[3:0] = c[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd5) begin
        r[7:4] = c[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) begin
          r[11:8] = c[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (c[15:12] == 4'd5) ? 4'd0 : c[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Next-state logic: clear beats start_stop beats lap; ticks count only in RUN.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    tick     = tick_in & ~tick_q;
    count_en = (state == RUN) && tick;
    state_n  = state;
    cnt_n    = cnt;
    lap_n    = lap_reg;
    lap_on_n = lap_active;
    wrap_n   = 1'b0;

    if (clear) begin
      state_n  = IDLE;
      cnt_n    = '0;
      lap_n    = '0;
      lap_on_n = 1'b0;
    end else begin
      // A tick on the cycle we leave RUN still counts; entering RUN it does not.
      if (count_en) begin
        cnt_n  = bcd_inc(cnt);
        wrap_n = (cnt == MAX_COUNT);
      end
      if (start_stop) begin
        state_n = (state == RUN) ? PAUSE : RUN;
      end else if (lap) begin
        if (state == RUN) begin
          if (lap_active) begin
            lap_on_n = 1'b0;
          end else begin
            lap_on_n = 1'b1;
            lap_n    = cnt;  // pre-increment value
          end
        end else begin
          lap_on_n = 1'b0;
        end
      end
    end
  end

  // State, count, lap and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      tick_q     <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      wrap       <= 1'b0;
      running    <= 1'b0;
      min_t      <= '0;
      min_o      <= '0;
      sec_t      <= '0;
      sec_o      <= '0;
    end else begin
      tick_q     <= tick_in;
      state      <= state_n;
      cnt        <= cnt_n;
      lap_reg    <= lap_n;
      lap_active <= lap_on_n;
      wrap       <= wrap_n;
      running    <= (state_n == RUN);
      {min_t, min_o, sec_t, sec_o} <= lap_on_n ? lap_n : cnt_n;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd. A seconds-based reference model
// (plain integer arithmetic) tracks the expected outputs every cycle.
module tb_stopwatch_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, lap_active, wrap;

  stopwatch_bcd dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .min_t      (min_t),
    .min_o      (min_o),
    .sec_t      (sec_t),
    .sec_o      (sec_o),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause; times in whole seconds.
  int m_mode, m_sec, m_lap_sec;
  bit m_tick_q, m_lap_act, m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [18:0] model_out();
    return {to_bcd(m_lap_act ? m_lap_sec : m_sec), m_mode == 1, m_lap_act, m_wrap};
  endfunction

  function automatic logic [15:0] digits();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  function automatic logic [18:0] dut_out();
    return {min_t, min_o, sec_t, sec_o, running, lap_active, wrap};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sec = 0; m_lap_sec = 0;
    m_tick_q = 0; m_lap_act = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    bit edge_seen, inc;
    edge_seen = tick_in && !m_tick_q;
    m_tick_q  = tick_in;
    if (clear) begin
      m_mode = 0; m_sec = 0; m_lap_sec = 0; m_lap_act = 0; m_wrap = 0;
    end else begin
      inc    = (m_mode == 1) && edge_seen;
      m_wrap = inc && (m_sec == 3599);
      if (lap && !start_stop) begin
        if (m_mode == 1) begin
          if (!m_lap_act) m_lap_sec = m_sec;
          m_lap_act = !m_lap_act;
        end else begin
          m_lap_act = 0;
        end
      end
      if (start_stop) m_mode = (m_mode == 1) ? 2 : 1;
      if (inc) m_sec = (m_sec + 1) % 3600;
    end
  endtask

  // One clock: model follows the same sampled inputs, outputs compared 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic pulse(input bit ss, input bit cl, input bit lp);
    start_stop = ss; clear = cl; lap = lp;
    cyc();
    start_stop = 0; clear = 0; lap = 0;
  endtask

  task automatic tick_edge(input int hi, input int lo);
    tick_in = 1;
    repeat (hi) cyc();
    tick_in = 0;
    repeat (lo) cyc();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_out()), 32'h0);
    rst = 1;

    // Basic count: 12 edges, 4 high / 4 low.
    pulse(1, 0, 0);
    repeat (12) tick_edge(4, 4);
    check("basic_digits", 32'(digits()), 32'h0012);
    check("basic_running", 32'(running), 32'h1);

    // Rollover with carry checkpoints.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    for (int i = 1; i <= 3599; i++) begin
      tick_edge(1, 1);
      if (i == 10)  check("carry_00_10", 32'(digits()), 32'h0010);
      if (i == 60)  check("carry_01_00", 32'(digits()), 32'h0100);
      if (i == 600) check("carry_10_00", 32'(digits()), 32'h1000);
    end
    check("at_59_59", 32'(digits()), 32'h5959);
    check("no_wrap_yet", 32'(wrap), 32'h0);
    tick_in = 1;
    cyc();
    check("wrap_digits", 32'(digits()), 32'h0000);
    check("wrap_pulse", 32'(wrap), 32'h1);
    tick_in = 0;
    cyc();
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Pause / resume, including start_stop coincident with a tick.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    repeat (5) tick_edge(2, 2);
    pulse(1, 0, 0);
    repeat (3) tick_edge(2, 2);
    check("paused_hold", 32'(digits()), 32'h0005);
    check("paused_running", 32'(running), 32'h0);
    tick_in = 1; start_stop = 1;
    cyc();
    start_stop = 0;
    cyc();
    tick_in = 0;
    cyc();
    check("resume_no_count", 32'(digits()), 32'h0005);
    check("resume_running", 32'(running), 32'h1);
    tick_edge(2, 2);
    check("resume_next", 32'(digits()), 32'h0006);

    // Lap freeze, release, and release while paused.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    repeat (7) tick_edge(2, 2);
    pulse(0, 0, 1);
    check("lap_set", 32'(lap_active), 32'h1);
    repeat (4) tick_edge(2, 2);
    check("lap_frozen", 32'(digits()), 32'h0007);
    pulse(0, 0, 1);
    check("lap_release", 32'(digits()), 32'h0011);
    check("lap_cleared", 32'(lap_active), 32'h0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    check("lap_pause_frozen", 32'(lap_active), 32'h1);
    pulse(0, 0, 1);
    check("lap_pause_release", 32'(lap_active), 32'h0);

    // Clear beats start_stop and a tick in the same cycle.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    repeat (83) tick_edge(1, 1);
    check("at_01_23", 32'(digits()), 32'h0123);
    pulse(0, 0, 1);
    tick_in = 1; clear = 1; start_stop = 1;
    cyc();
    clear = 0; start_stop = 0; tick_in = 0;
    check("clear_prio", 32'(dut_out()), 32'h0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      start_stop = ($urandom_range(0, 40) == 0);
      lap        = ($urandom_range(0, 25) == 0);
      clear      = ($urandom_range(0, 300) == 0);
      cyc();
    end
    start_stop = 0; lap = 0; clear = 0; tick_in = 0;

    // Asynchronous reset mid-count, tick held high across release.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    repeat (42) tick_edge(2, 2);
    check("at_00_42", 32'(digits()), 32'h0042);
    cyc();
    #2;
    rst = 0;
    tick_in = 1;
    #1;
    model_reset();
    check("async_reset", 32'(dut_out()), 32'h0);
    @(negedge clk);
    rst = 1;
    pulse(1, 0, 0);
    repeat (4) cyc();
    check("held_tick_no_count", 32'(digits()), 32'h0000);
    tick_in = 0;
    cyc();
    tick_edge(2, 2);
    check("first_real_edge", 32'(digits()), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
